// File: rtl/approx_dadda_mul_pipe.sv
// Purpose : 3-stage unsigned WIDTH x WIDTH multiplier, per-transaction exact/approximate low columns.
// Latency : 3 cycles accept-to-out_valid, one transaction per cycle while out_ready is high.
// Backpr. : single global advance (!s3_valid || out_ready); on stall every stage and output holds.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          operand handshake; in_a, in_b, in_approx, in_tag travel with it
//   out_valid/out_ready        result handshake; out_prod, out_approx, out_tag travel with it
//   cnt_clr, approx_cnt        synchronous clear / saturating count of accepted approximate ops
module approx_dadda_mul_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 4,
    parameter int TAG_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_approx,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 out_approx,
    output logic [TAG_W-1:0]     out_tag,
    input  logic                 cnt_clr,
    output logic [15:0]          approx_cnt
);

    localparam int PW = 2 * WIDTH;
    localparam int NG = PW / 4;   // WIDTH is even, so PW is a whole number of 4-bit groups

    // ---------------- stage registers ----------------
    logic                 r_s1_vld;
    logic [WIDTH-1:0]     r_s1_a;
    logic [WIDTH-1:0]     r_s1_b;
    logic                 r_s1_apx;
    logic [TAG_W-1:0]     r_s1_tag;

    logic                 r_s2_vld;
    logic [PW-1:0]        r_s2_sum;
    logic [PW-1:0]        r_s2_car;
    logic                 r_s2_apx;
    logic [TAG_W-1:0]     r_s2_tag;

    logic                 r_s3_vld;
    logic [PW-1:0]        r_s3_prod;
    logic                 r_s3_apx;
    logic [TAG_W-1:0]     r_s3_tag;

    logic [15:0]          r_cnt;

    logic                 w_advance;
    logic                 w_accept;
    logic [PW-1:0]        w_sum;
    logic [PW-1:0]        w_car;
    logic [PW-1:0]        w_add;

    assign w_advance = !r_s3_vld || out_ready;
    assign w_accept  = in_valid && w_advance;
    assign in_ready  = w_advance;

    // ---------------- S2: partial products + carry-save reduction ----------------
    // In approximate mode the pp bits of columns below APPROX_COLS are removed from the
    // adder array and replaced by the OR of each column. Because those columns feed the
    // array only zeros, no carry can land below APPROX_COLS, so the OR bits can simply be
    // merged into the sum row.
    always_comb begin
        logic [PW-1:0] lo_mask;
        logic [PW-1:0] or_bits;
        logic [PW-1:0] row;
        logic [PW-1:0] s_acc;
        logic [PW-1:0] c_acc;
        logic [PW-1:0] t_sum;
        logic [PW-1:0] t_car;

        lo_mask = '0;
        or_bits = '0;
        row     = '0;
        s_acc   = '0;
        c_acc   = '0;
        t_sum   = '0;
        t_car   = '0;

        for (int c = 0; c < PW; c++) begin
            if (c < APPROX_COLS) begin
                lo_mask[c] = 1'b1;
            end
        end

        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if ((i + j) < APPROX_COLS) begin
                    or_bits[i+j] = or_bits[i+j] | (r_s1_a[j] & r_s1_b[i]);
                end
            end
        end

        // Row-by-row 3:2 compression keeps two rows whose sum is the exact column total.
        for (int i = 0; i < WIDTH; i++) begin
            row = PW'(r_s1_a & {WIDTH{r_s1_b[i]}}) << i;
            if (r_s1_apx) begin
                row = row & ~lo_mask;
            end
            t_sum = s_acc ^ c_acc ^ row;
            t_car = ((s_acc & c_acc) | (s_acc & row) | (c_acc & row)) << 1;
            s_acc = t_sum;
            c_acc = t_car;
        end

        w_sum = r_s1_apx ? (s_acc | or_bits) : s_acc;
        w_car = c_acc;
    end

    // ---------------- S3: carry-lookahead adder, 4-bit groups, carry-in 0 ----------------
    always_comb begin
        logic [3:0] gg;
        logic [3:0] pp;
        logic [3:0] cc;
        logic       gc;
        logic       grp_g;
        logic       grp_p;

        gg    = '0;
        pp    = '0;
        cc    = '0;
        gc    = 1'b0;
        grp_g = 1'b0;
        grp_p = 1'b0;
        w_add = '0;

        for (int g = 0; g < NG; g++) begin
            gg = r_s2_sum[4*g +: 4] & r_s2_car[4*g +: 4];
            pp = r_s2_sum[4*g +: 4] ^ r_s2_car[4*g +: 4];

            cc[0] = gc;
            cc[1] = gg[0] | (pp[0] & gc);
            cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & gc);
            cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                  | (pp[2] & pp[1] & pp[0] & gc);

            grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                  | (pp[3] & pp[2] & pp[1] & gg[0]);
            grp_p = &pp;

            w_add[4*g +: 4] = pp ^ cc;
            gc = grp_g | (grp_p & gc);
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s1_apx  <= 1'b0;
            r_s1_tag  <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_sum  <= '0;
            r_s2_car  <= '0;
            r_s2_apx  <= 1'b0;
            r_s2_tag  <= '0;
            r_s3_vld  <= 1'b0;
            r_s3_prod <= '0;
            r_s3_apx  <= 1'b0;
            r_s3_tag  <= '0;
        end else if (w_advance) begin
            r_s1_vld  <= in_valid;
            r_s1_a    <= in_a;
            r_s1_b    <= in_b;
            r_s1_apx  <= in_approx;
            r_s1_tag  <= in_tag;
            r_s2_vld  <= r_s1_vld;
            r_s2_sum  <= w_sum;
            r_s2_car  <= w_car;
            r_s2_apx  <= r_s1_apx;
            r_s2_tag  <= r_s1_tag;
            r_s3_vld  <= r_s2_vld;
            r_s3_prod <= w_add;
            r_s3_apx  <= r_s2_apx;
            r_s3_tag  <= r_s2_tag;
        end
    end

    // Clear wins over a same-cycle approximate accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_accept && in_approx && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign out_valid  = r_s3_vld;
    assign out_prod   = r_s3_prod;
    assign out_approx = r_s3_apx;
    assign out_tag    = r_s3_tag;
    assign approx_cnt = r_cnt;

endmodule

// File: tb/tb_approx_dadda_mul_pipe.sv
module tb_approx_dadda_mul_pipe;

    localparam int W  = 8;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic            in_approx;
    logic [TW-1:0]   in_tag;
    logic            out_ready;
    logic            cnt_clr;

    logic [2:0]      ird;
    logic [2:0]      ovld;
    logic [2:0]      oapx;
    logic [2*W-1:0]  oprod [3];
    logic [TW-1:0]   otag  [3];
    logic [15:0]     ocnt  [3];

    always #5 clk = ~clk;

    // Instance 0: K=0, instance 1: K=4 (main directed target), instance 2: K=WIDTH.
    for (genvar u = 0; u < 3; u++) begin : g_dut
        approx_dadda_mul_pipe #(
            .WIDTH       (W),
            .APPROX_COLS ((u == 0) ? 0 : ((u == 1) ? 4 : W)),
            .TAG_W       (TW)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid),
            .in_ready   (ird[u]),
            .in_a       (in_a),
            .in_b       (in_b),
            .in_approx  (in_approx),
            .in_tag     (in_tag),
            .out_valid  (ovld[u]),
            .out_ready  (out_ready),
            .out_prod   (oprod[u]),
            .out_approx (oapx[u]),
            .out_tag    (otag[u]),
            .cnt_clr    (cnt_clr),
            .approx_cnt (ocnt[u])
        );
    end

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          ap;
        logic [TW-1:0] tag;
    } txn_t;

    txn_t          sbq[$];
    logic [TW-1:0] dlv_tags[$];
    int            n_total = 0;
    int            n_pass  = 0;
    int            n_fail  = 0;
    logic [15:0]   cnt_model;

    function automatic int kval(input int u);
        return (u == 0) ? 0 : ((u == 1) ? 4 : W);
    endfunction

    // Column-wise reference: OR for columns below k, population count weighted 2^c above.
    function automatic logic [15:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ap, input int k);
        int          cnt;
        int          j;
        logic [31:0] s;
        logic [15:0] orb;
        if (!ap) return {8'd0, a} * {8'd0, b};
        s   = 0;
        orb = 0;
        for (int c = 0; c < 2 * W; c++) begin
            cnt = 0;
            for (int i = 0; i < W; i++) begin
                j = c - i;
                if (j >= 0 && j < W) cnt += int'(a[j] & b[i]);
            end
            if (c < k) orb[c] = (cnt != 0);
            else       s = s + (32'(cnt) << c);
        end
        return s[15:0] + orb;
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Inputs are driven at the falling edge; handshakes are sampled 1 time unit later,
    // then the task returns at the next falling edge.
    task automatic tick(output bit acc);
        txn_t t;
        #1;
        acc = in_valid && ird[1];
        if (ovld[1] && out_ready) begin
            if (sbq.size() == 0) begin
                check("spurious_out", 32'(ovld[1]), 32'd0);
            end else begin
                t = sbq.pop_front();
                dlv_tags.push_back(otag[1]);
                for (int u = 0; u < 3; u++) begin
                    check($sformatf("sb_vld_u%0d", u), 32'(ovld[u]), 32'd1);
                    check($sformatf("sb_prod_u%0d", u), 32'(oprod[u]), 32'(golden(t.a, t.b, t.ap, kval(u))));
                    check($sformatf("sb_apx_u%0d", u), 32'(oapx[u]), 32'(t.ap));
                    check($sformatf("sb_tag_u%0d", u), 32'(otag[u]), 32'(t.tag));
                end
            end
        end
        if (acc) begin
            t.a = in_a; t.b = in_b; t.ap = in_approx; t.tag = in_tag;
            sbq.push_back(t);
        end
        if (cnt_clr) cnt_model = 16'd0;
        else if (acc && in_approx && cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        in_valid = 1'b0;
        repeat (n) tick(a);
    endtask

    task automatic drain();
        bit a;
        int b;
        in_valid = 1'b0;
        b = 0;
        while (sbq.size() > 0 && b < 40) begin
            tick(a);
            b++;
        end
        check("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    task automatic check_reset(input string p);
        for (int u = 0; u < 3; u++) begin
            check({p, "_vld"},  32'(ovld[u]),  32'd0);
            check({p, "_prod"}, 32'(oprod[u]), 32'd0);
            check({p, "_apx"},  32'(oapx[u]),  32'd0);
            check({p, "_tag"},  32'(otag[u]),  32'd0);
            check({p, "_rdy"},  32'(ird[u]),   32'd1);
            check({p, "_cnt"},  32'(ocnt[u]),  32'd0);
        end
    endtask

    initial begin
        bit          acc;
        int          n_acc;
        int          budget;
        logic [7:0]  ca [4];
        logic [7:0]  cb [4];
        logic [15:0] ce [4];

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = 1'b0;
        in_tag = '0; out_ready = 1'b1; cnt_clr = 1'b0; cnt_model = 16'd0;
        @(negedge clk);
        check_reset("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        // Exact corners, back-to-back, 3-cycle latency.
        ca = '{8'd0, 8'd255, 8'd1, 8'd128};
        cb = '{8'd0, 8'd255, 8'd200, 8'd2};
        ce = '{16'd0, 16'd65025, 16'd200, 16'd256};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                in_valid = 1'b1; in_a = ca[i]; in_b = cb[i]; in_approx = 1'b0; in_tag = TW'(i);
            end else begin
                in_valid = 1'b0;
            end
            tick(acc);
            if (i < 4) check("corner_acc", 32'(acc), 32'd1);
            if (i >= 2) begin
                check("corner_vld", 32'(ovld[1]), 32'd1);
                check("corner_prod", 32'(oprod[1]), 32'(ce[i-2]));
            end
        end
        tick(acc);
        check("corner_empty", 32'(ovld[1]), 32'd0);

        // Approximate 0x0F * 0x0F, K=4 -> 191; K=0 gives the exact 225.
        in_valid = 1'b1; in_a = 8'h0F; in_b = 8'h0F; in_approx = 1'b1; in_tag = 4'd5;
        tick(acc);
        in_valid = 1'b0;
        tick(acc); tick(acc);
        check("apx_vld", 32'(ovld[1]), 32'd1);
        check("apx_prod_k4", 32'(oprod[1]), 32'd191);
        check("apx_flag", 32'(oapx[1]), 32'd1);
        check("apx_prod_k0", 32'(oprod[0]), 32'd225);
        check("apx_tag", 32'(otag[1]), 32'd5);
        in_valid = 1'b1; in_approx = 1'b0; in_tag = 4'd6;
        tick(acc);
        in_valid = 1'b0;
        tick(acc); tick(acc);
        check("exact_prod_k4", 32'(oprod[1]), 32'd225);
        check("exact_flag", 32'(oapx[1]), 32'd0);
        idle(3);

        // Backpressure: tags 1..4 with out_ready low.
        dlv_tags.delete();
        out_ready = 1'b0;
        for (int tg = 1; tg <= 3; tg++) begin
            in_valid = 1'b1; in_a = 8'(tg * 40 + 3); in_b = 8'(tg * 17 + 1);
            in_approx = tg[0]; in_tag = TW'(tg);
            tick(acc);
            check("bp_acc", 32'(acc), 32'd1);
        end
        in_valid = 1'b1; in_a = 8'd163; in_b = 8'd69; in_approx = 1'b0; in_tag = 4'd4;
        for (int s = 0; s < 5; s++) begin
            check("bp_in_ready", 32'(ird[1]), 32'd0);
            check("bp_hold_vld", 32'(ovld[1]), 32'd1);
            check("bp_hold_tag", 32'(otag[1]), 32'd1);
            check("bp_hold_prod", 32'(oprod[1]), 32'(golden(8'd43, 8'd18, 1'b1, 4)));
            tick(acc);
            check("bp_no_acc", 32'(acc), 32'd0);
        end
        check("bp_hold_tag_end", 32'(otag[1]), 32'd1);
        out_ready = 1'b1;
        tick(acc);
        check("bp_acc4", 32'(acc), 32'd1);
        drain();
        check("bp_dlv_count", 32'(dlv_tags.size()), 32'd4);
        for (int i = 0; i < dlv_tags.size(); i++) begin
            check("bp_order", 32'(dlv_tags[i]), 32'(i + 1));
        end

        // Counter saturation and clear priority.
        cnt_clr = 1'b1; in_valid = 1'b0;
        tick(acc);
        cnt_clr = 1'b0;
        check("cnt_clr_idle", 32'(ocnt[1]), 32'd0);
        in_valid = 1'b1; in_approx = 1'b1;
        for (int n = 0; n < 65534; n++) begin
            in_a = 8'($urandom); in_b = 8'($urandom); in_tag = 4'($urandom);
            tick(acc);
        end
        check("cnt_preload", 32'(ocnt[1]), 32'h0000FFFE);
        for (int n = 0; n < 3; n++) begin
            tick(acc);
            check("cnt_sat", 32'(ocnt[1]), 32'h0000FFFF);
        end
        cnt_clr = 1'b1;
        tick(acc);
        cnt_clr = 1'b0;
        check("cnt_clr_acc", 32'(acc), 32'd1);
        check("cnt_clr_wins", 32'(ocnt[1]), 32'd0);
        tick(acc);
        check("cnt_after_clr", 32'(ocnt[1]), 32'd1);
        drain();

        // Reset with three transactions in flight.
        for (int n = 0; n < 3; n++) begin
            in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
            in_approx = 1'($urandom); in_tag = 4'($urandom);
            tick(acc);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset("rst_mid");
        sbq.delete();
        cnt_model = 16'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick(acc);
            check("rst_quiet", 32'(ovld[1]), 32'd0);
        end
        in_valid = 1'b1; in_a = 8'd77; in_b = 8'd91; in_approx = 1'b0; in_tag = 4'd9;
        tick(acc);
        in_valid = 1'b0;
        check("rst_lat1", 32'(ovld[1]), 32'd0);
        tick(acc);
        check("rst_lat2", 32'(ovld[1]), 32'd0);
        tick(acc);
        check("rst_lat3", 32'(ovld[1]), 32'd1);
        check("rst_prod", 32'(oprod[1]), 32'd7007);
        drain();

        // Randomised regression across K = 0, 4, WIDTH.
        n_acc  = 0;
        budget = 0;
        while (n_acc < 2000 && budget < 20000) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_approx = 1'($urandom_range(0, 1));
            in_tag    = 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            tick(acc);
            if (acc) n_acc++;
            budget++;
        end
        check("rand_accepts", 32'(n_acc), 32'd2000);
        out_ready = 1'b1;
        drain();
        check("rand_cnt", 32'(ocnt[1]), 32'(cnt_model));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
